// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback select.
// Registers the selected writeback value, destination register and write enable,
// and keeps a sticky halt flag and a retired-instruction counter.
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   stall, flush                hold all state / insert a bubble (flush wins)
//   in_valid, instruction       MEM-stage instruction (rd = instruction[11:7])
//   ALU_result, DataWord,
//   PC_plus4, imm32             writeback candidates
//   opcode, RegWrite, WbSel     control from mem_access
//   wb_wEn, wb_rd, wb_data      register-file write port
//   fwd_valid                   WB forwarding entry valid
//   halt                        sticky halt-opcode-retired flag
//   retired_count               retired valid instruction count (wraps)
module mem_wb_stage #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [6:0]  HALT_OPCODE = 7'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          instruction,
    input  logic [31:0]          ALU_result,
    input  logic [31:0]          DataWord,
    input  logic [31:0]          PC_plus4,
    input  logic [31:0]          imm32,
    input  logic [6:0]           opcode,
    input  logic                 RegWrite,
    input  logic [1:0]           WbSel,
    output logic                 wb_wEn,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 fwd_valid,
    output logic                 halt,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    logic              wen_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wb_mux_c;
    logic [RD_W-1:0]   rd_c;
    logic              unused_bits;

    assign rd_c        = instruction[11:7];
    assign unused_bits = &{instruction[31:12], instruction[6:0], 1'b0};

    // Writeback source select, evaluated ahead of the register.
    always_comb begin
        wb_mux_c = ALU_result;
        unique case (WbSel)
            2'b00:   wb_mux_c = ALU_result;
            2'b01:   wb_mux_c = DataWord;
            2'b10:   wb_mux_c = PC_plus4;
            2'b11:   wb_mux_c = imm32;
            default: wb_mux_c = ALU_result;
        endcase
    end

    // Pipeline register, halt flag and retire counter; reset > flush > stall > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_q         <= 1'b0;
            rd_q          <= '0;
            data_q        <= '0;
            halt          <= 1'b0;
            retired_count <= '0;
        end else if (flush) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (!stall) begin
            // x0 is hardwired to zero, so rd == 0 never produces a write.
            wen_q  <= in_valid & RegWrite & (rd_c != RD_W'(0));
            rd_q   <= rd_c;
            data_q <= wb_mux_c;
            if (in_valid) begin
                retired_count <= retired_count + CNT_WIDTH'(1);
                if (opcode == HALT_OPCODE) begin
                    halt <= 1'b1;
                end
            end
        end
    end

    assign wb_wEn    = wen_q;
    assign wb_rd     = rd_q;
    assign wb_data   = data_q;
    assign fwd_valid = wen_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage (counter width 4).
module tb_mem_wb_stage;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [31:0]   instruction;
    logic [31:0]   ALU_result;
    logic [31:0]   DataWord;
    logic [31:0]   PC_plus4;
    logic [31:0]   imm32;
    logic [6:0]    opcode;
    logic          RegWrite;
    logic [1:0]    WbSel;
    logic          wb_wEn;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          fwd_valid;
    logic          halt;
    logic [CW-1:0] retired_count;

    mem_wb_stage #(.CNT_WIDTH(CW), .HALT_OPCODE(7'h00)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .instruction(instruction), .ALU_result(ALU_result),
        .DataWord(DataWord), .PC_plus4(PC_plus4), .imm32(imm32), .opcode(opcode),
        .RegWrite(RegWrite), .WbSel(WbSel), .wb_wEn(wb_wEn), .wb_rd(wb_rd),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .halt(halt),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic          wen;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          chk_data;
        logic          hlt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    // Reference state of the stage.
    logic          m_wen  = 1'b0;
    logic [4:0]    m_rd   = '0;
    logic [31:0]   m_data = '0;
    logic          m_halt = 1'b0;
    logic [CW-1:0] m_cnt  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_wen = 1'b0; m_rd = '0; m_data = '0; m_halt = 1'b0; m_cnt = '0;
    endtask

    // Compute expected result from the currently driven inputs and queue it.
    task automatic push_expect(input string tag);
        exp_t e;
        logic [31:0] mux;
        logic [4:0]  rd;
        rd = instruction[11:7];
        case (WbSel)
            2'b00: mux = ALU_result;
            2'b01: mux = DataWord;
            2'b10: mux = PC_plus4;
            default: mux = imm32;
        endcase
        e.chk_data = 1'b1;
        if (flush) begin
            m_wen = 1'b0;
            e.chk_data = 1'b0;
        end else if (!stall) begin
            m_wen  = in_valid && RegWrite && (rd != 5'd0);
            m_rd   = rd;
            m_data = mux;
            if (in_valid) begin
                m_cnt = m_cnt + 4'd1;
                if (opcode == 7'h00) m_halt = 1'b1;
            end
        end
        e.tag = tag; e.wen = m_wen; e.rd = m_rd; e.data = m_data;
        e.hlt = m_halt; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".wen"}, 32'(wb_wEn), 32'(e.wen));
            chk({e.tag, ".fwd"}, 32'(fwd_valid), 32'(e.wen));
            if (e.chk_data) begin
                chk({e.tag, ".rd"}, 32'(wb_rd), 32'(e.rd));
                chk({e.tag, ".data"}, wb_data, e.data);
            end
            chk({e.tag, ".halt"}, 32'(halt), 32'(e.hlt));
            chk({e.tag, ".cnt"}, 32'(retired_count), 32'(e.cnt));
        end
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge.
    task automatic step(input string tag);
        push_expect(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [6:0] op);
        in_valid    = v;
        RegWrite    = rw;
        instruction = {20'h00000, rd, 7'h33};
        WbSel       = sel;
        opcode      = op;
        stall       = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".wen"}, 32'(wb_wEn), 32'd0);
        chk({tag, ".fwd"}, 32'(fwd_valid), 32'd0);
        chk({tag, ".rd"}, 32'(wb_rd), 32'd0);
        chk({tag, ".data"}, wb_data, 32'd0);
        chk({tag, ".halt"}, 32'(halt), 32'd0);
        chk({tag, ".cnt"}, 32'(retired_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        instruction = '0; ALU_result = '0; DataWord = '0; PC_plus4 = '0;
        imm32 = '0; opcode = 7'h33; RegWrite = 1'b0; WbSel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_init");
        reset = 1'b0;

        // Load from DataWord.
        set_instr(1'b1, 1'b1, 5'd5, 2'b01, 7'h03);
        DataWord = 32'hDEADBEEF; ALU_result = 32'h1111_0000;
        step("load_dw");
        chk("load_dw.const_data", wb_data, 32'hDEADBEEF);
        chk("load_dw.const_cnt", 32'(retired_count), 32'd1);

        // rd = x0 suppresses the write; PC_plus4 still selected and counted.
        set_instr(1'b1, 1'b1, 5'd0, 2'b10, 7'h6F);
        PC_plus4 = 32'h104;
        step("x0_pc4");
        chk("x0_pc4.const_wen", 32'(wb_wEn), 32'd0);

        // Immediate select and a bubble.
        set_instr(1'b1, 1'b1, 5'd9, 2'b11, 7'h37);
        imm32 = 32'hABCD_E000;
        step("lui_imm");
        set_instr(1'b0, 1'b1, 5'd3, 2'b00, 7'h33);
        ALU_result = 32'h55;
        step("bubble");

        // Load, then stall, then stall+flush.
        set_instr(1'b1, 1'b1, 5'd7, 2'b00, 7'h33);
        ALU_result = 32'h10;
        step("load_rd7");
        set_instr(1'b1, 1'b1, 5'd12, 2'b00, 7'h00);
        ALU_result = 32'h999; stall = 1'b1;
        step("stall_hold");
        chk("stall_hold.const_data", wb_data, 32'h10);
        stall = 1'b1; flush = 1'b1;
        step("stall_flush");

        // Asynchronous reset mid-stream, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        model_reset();
        #1;
        reset = 1'b0;
        @(negedge clk);

        // Counter wrap: 17 retirements, 15 -> 0 -> 1.
        for (int i = 1; i <= 17; i++) begin
            set_instr(1'b1, 1'b1, 5'(i), 2'b00, 7'h13);
            ALU_result = 32'(i * 3);
            step($sformatf("wrap%0d", i));
            if (i == 15) chk("wrap.const_15", 32'(retired_count), 32'd15);
            if (i == 16) chk("wrap.const_0", 32'(retired_count), 32'd0);
            if (i == 17) chk("wrap.const_1", 32'(retired_count), 32'd1);
        end

        // Halt opcode is sticky and later instructions still flow.
        set_instr(1'b1, 1'b0, 5'd1, 2'b00, 7'h00);
        step("halt_set");
        chk("halt_set.const", 32'(halt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 5'(20 + i), 2'b00, 7'h33);
            ALU_result = 32'(100 + i);
            step($sformatf("halt_hold%0d", i));
        end
        chk("halt_hold.const", 32'(halt), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("halt_reset");
        model_reset();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
